// File: rtl/alu_pipe_if.sv
// Operand/opcode beat and result handshake bundle for alu_pipe.
// master = producer/consumer side (testbench or upstream), slave = the ALU.
interface alu_interface;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned OW = 16;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [SW-1:0] s;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered 8-bit ALU with valid/ready on both sides; one result per clock for opcodes 0-D.
// Define ALU_DIV_EN to build the iterative 8-step restoring divider for DIV/MOD (otherwise they return 0).
module alu_pipe (
  input  logic        clk,
  input  logic        rst,
  alu_interface.slave bus
);

  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 4;
  localparam int unsigned OW  = 16;
  localparam int unsigned SHW = 3;

  localparam logic [SW-1:0] OP_ADD  = 4'h0;
  localparam logic [SW-1:0] OP_SUB  = 4'h1;
  localparam logic [SW-1:0] OP_MUL  = 4'h2;
  localparam logic [SW-1:0] OP_AND  = 4'h3;
  localparam logic [SW-1:0] OP_OR   = 4'h4;
  localparam logic [SW-1:0] OP_XOR  = 4'h5;
  localparam logic [SW-1:0] OP_NAND = 4'h6;
  localparam logic [SW-1:0] OP_NOT  = 4'h7;
  localparam logic [SW-1:0] OP_SHL  = 4'h8;
  localparam logic [SW-1:0] OP_SHR  = 4'h9;
  localparam logic [SW-1:0] OP_ROL  = 4'hA;
  localparam logic [SW-1:0] OP_ROR  = 4'hB;
  localparam logic [SW-1:0] OP_EQ   = 4'hC;
  localparam logic [SW-1:0] OP_GT   = 4'hD;
  localparam logic [SW-1:0] OP_DIV  = 4'hE;
  localparam logic [SW-1:0] OP_MOD  = 4'hF;

  logic [OW-1:0]   out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_c;
  logic            accept_c;
  logic [OW-1:0]   alu_res_c;
  logic [SHW-1:0]  sh_c;
  logic [2*DW-1:0] dbl_c;
  logic [2*DW-1:0] rot_c;

  assign accept_c      = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

  // Single-cycle result for the beat currently on the bus
  always_comb begin
    sh_c      = bus.b[SHW-1:0];
    dbl_c     = {bus.a, bus.a};
    rot_c     = '0;
    alu_res_c = '0;
    case (bus.s)
      OP_ADD:  alu_res_c = OW'(bus.a) + OW'(bus.b);
      OP_SUB:  alu_res_c = OW'(bus.a) - OW'(bus.b);
      OP_MUL:  alu_res_c = OW'(bus.a) * OW'(bus.b);
      OP_AND:  alu_res_c = {{DW{1'b0}}, bus.a & bus.b};
      OP_OR:   alu_res_c = {{DW{1'b0}}, bus.a | bus.b};
      OP_XOR:  alu_res_c = {{DW{1'b0}}, bus.a ^ bus.b};
      OP_NAND: alu_res_c = {{DW{1'b0}}, ~(bus.a & bus.b)};
      OP_NOT:  alu_res_c = {{DW{1'b0}}, ~bus.a};
      OP_SHL:  alu_res_c = OW'(bus.a) << sh_c;
      OP_SHR:  alu_res_c = {{DW{1'b0}}, bus.a >> sh_c};
      OP_ROL: begin
        // Rotating a doubled copy; a shift of 8 (sh=0) returns a unchanged
        rot_c     = dbl_c >> (4'(DW) - 4'(sh_c));
        alu_res_c = {{DW{1'b0}}, rot_c[DW-1:0]};
      end
      OP_ROR: begin
        rot_c     = dbl_c >> sh_c;
        alu_res_c = {{DW{1'b0}}, rot_c[DW-1:0]};
      end
      OP_EQ:   alu_res_c = {{(OW-1){1'b0}}, bus.a == bus.b};
      OP_GT:   alu_res_c = {{(OW-1){1'b0}}, bus.a > bus.b};
`ifdef ALU_DIV_EN
      OP_DIV,
      OP_MOD:  alu_res_c = (bus.b == '0) ? {OW{1'b1}} : '0;
`else
      OP_DIV,
      OP_MOD:  alu_res_c = '0;
`endif
      default: alu_res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_DIV_EN
  typedef enum logic {IDLE, DIV} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dsr_q, dsr_d;
  logic          mod_q, mod_d;
  logic          div_start_c;
  logic [DW:0]   rem_sh_c;
  logic [DW:0]   rem_sub_c;
  logic          step_ge_c;
  logic [DW-1:0] quo_nxt_c;
  logic [DW-1:0] rem_nxt_c;

  assign in_ready_c  = !rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign div_start_c = accept_c && ((bus.s == OP_DIV) || (bus.s == OP_MOD)) && (bus.b != '0);

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_sh_c  = {rem_q, quo_q[DW-1]};
    rem_sub_c = rem_sh_c - {1'b0, dsr_q};
    step_ge_c = (rem_sh_c >= {1'b0, dsr_q});
    quo_nxt_c = {quo_q[DW-2:0], step_ge_c};
    rem_nxt_c = step_ge_c ? rem_sub_c[DW-1:0] : rem_sh_c[DW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    mod_d       = mod_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (div_start_c) begin
          state_d = DIV;
          cnt_d   = '0;
          quo_d   = bus.a;
          rem_d   = '0;
          dsr_d   = bus.b;
          mod_d   = (bus.s == OP_MOD);
        end else if (accept_c) begin
          out_d       = alu_res_c;
          out_valid_d = 1'b1;
        end
      end
      DIV: begin
        quo_d = quo_nxt_c;
        rem_d = rem_nxt_c;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_d       = mod_q ? {{DW{1'b0}}, rem_nxt_c} : {{DW{1'b0}}, quo_nxt_c};
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      mod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      mod_q   <= mod_d;
    end
  end
`else
  assign in_ready_c = !rst && (!out_valid_q || bus.out_ready);

  // Every opcode completes at the accepting edge
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept_c) begin
      out_d       = alu_res_c;
      out_valid_d = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed plus randomized bench for alu_pipe against an arithmetic reference model.
// Honours ALU_DIV_EN to pick the expected divide behaviour and latency.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_interface bus_if ();

  alu_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from the opcode table, using integer arithmetic
  function automatic logic [15:0] model(input int a, input int b, input int s);
    int sh;
    int r;
    sh = b % 8;
    r  = 0;
    case (s)
      0:  r = a + b;
      1:  r = (a - b) & 'hFFFF;
      2:  r = a * b;
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = (~(a & b)) & 'hFF;
      7:  r = (~a) & 'hFF;
      8:  r = (a << sh) & 'hFFFF;
      9:  r = a >> sh;
      10: r = ((a << sh) | (a >> (8 - sh))) & 'hFF;
      11: r = ((a >> sh) | (a << (8 - sh))) & 'hFF;
      12: r = (a == b) ? 1 : 0;
      13: r = (a > b) ? 1 : 0;
`ifdef ALU_DIV_EN
      14: r = (b == 0) ? 'hFFFF : a / b;
      15: r = (b == 0) ? 'hFFFF : a % b;
`else
      14: r = 0;
      15: r = 0;
`endif
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic int model_lat(input int b, input int s);
`ifdef ALU_DIV_EN
    return (s >= 14 && b != 0) ? 8 : 0;
`else
    return 0;
`endif
  endfunction

  // Present a beat and hold it until the accepting edge (bounded)
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    int n;
    n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.a = a;
    bus_if.b = b;
    bus_if.s = s;
    #1;
    while (!bus_if.in_ready && n < 30) begin
      tick();
      n++;
    end
    check("accept_timeout", 32'(n < 30), 32'd1);
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  // Called right after the accepting edge; lat counts edges until out_valid shows
  task automatic wait_result(input string tag, input logic [15:0] exp, input int exp_lat);
    int lat;
    int low;
    lat = 0;
    low = 0;
    while (!bus_if.out_valid && lat < 20) begin
      if (!bus_if.in_ready) low++;
      tick();
      lat++;
    end
    check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    check({tag, "_out"}, 32'(bus_if.out), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(low), 32'(exp_lat));
  endtask

  initial begin
    int ra, rb, rs, k;
    logic [15:0] exp;
    logic seen;

    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.s         = '0;
    bus_if.out_ready = 1'b1;
    repeat (2) tick();
    check("reset_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset_out", 32'(bus_if.out), 32'h0);
    check("reset_ready", 32'(bus_if.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_ready", 32'(bus_if.in_ready), 32'd1);

    // Back-to-back streaming
    bus_if.in_valid = 1'b1;
    bus_if.a = 8'd200; bus_if.b = 8'd100; bus_if.s = 4'h0;
    #1;
    check("stream_ready0", 32'(bus_if.in_ready), 32'd1);
    tick();
    check("stream_add_valid", 32'(bus_if.out_valid), 32'd1);
    check("stream_add", 32'(bus_if.out), 32'h012C);
    bus_if.a = 8'd255; bus_if.b = 8'd255; bus_if.s = 4'h2;
    #1;
    check("stream_ready1", 32'(bus_if.in_ready), 32'd1);
    tick();
    check("stream_mul", 32'(bus_if.out), 32'hFE01);
    bus_if.a = 8'd3; bus_if.b = 8'd5; bus_if.s = 4'h1;
    tick();
    check("stream_sub", 32'(bus_if.out), 32'hFFFE);
    check("stream_sub_valid", 32'(bus_if.out_valid), 32'd1);
    bus_if.in_valid = 1'b0;
    tick();
    check("stream_drain", 32'(bus_if.out_valid), 32'd0);

    // Backpressure holds the result and blocks new beats
    bus_if.out_ready = 1'b0;
    send(8'hAA, 8'h0F, 4'h5);
    check("bp_xor", 32'(bus_if.out), 32'h00A5);
    bus_if.in_valid = 1'b1;
    bus_if.a = 8'd1; bus_if.b = 8'd2; bus_if.s = 4'h0;
    repeat (4) begin
      #1;
      check("bp_ready_low", 32'(bus_if.in_ready), 32'd0);
      tick();
      check("bp_hold_out", 32'(bus_if.out), 32'h00A5);
      check("bp_hold_valid", 32'(bus_if.out_valid), 32'd1);
    end
    bus_if.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus_if.in_ready), 32'd1);
    tick();
    bus_if.in_valid = 1'b0;
    check("bp_next_out", 32'(bus_if.out), 32'h0003);
    check("bp_next_valid", 32'(bus_if.out_valid), 32'd1);
    tick();
    check("bp_drained", 32'(bus_if.out_valid), 32'd0);

    // Reset for two cycles in the middle of traffic
    bus_if.in_valid = 1'b1;
    bus_if.a = 8'd7; bus_if.b = 8'd9; bus_if.s = 4'h0;
    tick();
    check("mid_pre_valid", 32'(bus_if.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus_if.in_ready), 32'd0);
    repeat (2) begin
      tick();
      check("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
      check("mid_rst_out", 32'(bus_if.out), 32'h0);
      check("mid_rst_ready_hold", 32'(bus_if.in_ready), 32'd0);
    end
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    #1;
    check("mid_rst_release", 32'(bus_if.in_ready), 32'd1);
    tick();

    // Divide, modulo and divide-by-zero
    send(8'd200, 8'd7, 4'hE);
    wait_result("div_200_7", model(200, 7, 14), model_lat(7, 14));
    send(8'd200, 8'd7, 4'hF);
    wait_result("mod_200_7", model(200, 7, 15), model_lat(7, 15));
    send(8'd9, 8'd0, 4'hE);
    wait_result("div_by_zero", model(9, 0, 14), model_lat(0, 14));
`ifdef ALU_DIV_EN
    check("div_const", 32'(bus_if.out), 32'hFFFF);
`else
    check("div_const", 32'(bus_if.out), 32'h0000);
`endif
    tick();

    // Reset while the divider is iterating
    send(8'd255, 8'd3, 4'hE);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_div_valid", 32'(bus_if.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_div_ready", 32'(bus_if.in_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus_if.out_valid) seen = 1'b1;
    end
    check("rst_div_no_result", 32'(seen), 32'd0);
    send(8'd1, 8'd1, 4'h0);
    wait_result("rst_div_add", 16'h0002, 0);

    // Randomized beats with random output stalls
    for (int i = 0; i < 80; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 15));
      exp = model(ra, rb, rs);
      bus_if.out_ready = 1'b1;
      send(8'(ra), 8'(rb), 4'(rs));
      wait_result($sformatf("rand%0d_op%0h", i, rs), exp, model_lat(rb, rs));
      k = int'($urandom_range(0, 2));
      bus_if.out_ready = 1'b0;
      for (int j = 0; j < k; j++) begin
        tick();
        check("rand_hold_out", 32'(bus_if.out), 32'(exp));
        check("rand_hold_valid", 32'(bus_if.out_valid), 32'd1);
        check("rand_hold_ready", 32'(bus_if.in_ready), 32'd0);
      end
      bus_if.out_ready = 1'b1;
    end
    tick();
    check("final_drain", 32'(bus_if.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
